iq_lane_packer: RTL and testbench
=================================

# iq_lane_packer

Packs a stream of single I/Q sample pairs (16-bit R, 16-bit Q per beat) into 256-bit eight-lane words for the parallel slicing stage that splits each word back into r1/q1 … r8/q8 lines. It sits directly upstream of that stage. It provides frame alignment (start/end of frame), zero-fill of partial words, a ready/valid handshake on both sides, and an error counter for truncated frames.

## Interface
- ERR_CNT_W, 16, width of the truncated-frame error counter
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  packer can accept a sample this cycle
- s_r  in  16  real (I) sample
- s_q  in  16  imaginary (Q) sample
- s_sof  in  1  sample is first of a frame; qualified by s_valid && s_ready
- s_eof  in  1  sample is last of a frame; qualified by s_valid && s_ready
- m_data  out  256  packed word
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts word
- m_last  out  1  word closed by s_eof
- m_fill  out  4  number of valid lanes in word, 1..8
- err_count  out  ERR_CNT_W  count of partial words discarded by s_sof; saturating

## Operation
- Lane k is numbered 1..8. Its R sample goes to m_data[32k-17:32k-32] and its Q sample to m_data[32k-1:32k-16]. Lane 1 R is therefore bits 15:0 and lane 8 Q is bits 255:240.
- Internal state:
  - lane index idx, 0..7, the next lane to write.
  - 256-bit accumulator acc.
  - one-entry output register holding m_data, m_valid, m_last and m_fill.
- Accept: a beat is accepted when s_valid && s_ready. On an accepted beat, {s_q, s_r} is written into lane idx+1 of acc.
- s_ready = !reset && (!m_valid || m_ready). The output register must be free or draining in the same cycle.
- Word completion: an accepted beat completes the word when idx==7 or s_eof==1. On completion:
  - the output register loads acc with this beat merged in; lanes above the beat's lane are zero;
  - m_fill = idx+1;
  - m_last = s_eof;
  - acc is cleared and idx returns to 0.
- Otherwise an accepted beat sets idx = idx+1.
- s_sof with idx==0: normal; the beat goes to lane 1.
- s_sof with idx!=0 (truncated frame):
  - the pending partial acc is discarded and acc is cleared;
  - err_count increments, saturating at all-ones;
  - the beat is written to lane 1 and idx becomes 1, or the word completes immediately if s_eof is also set.
- s_sof and s_eof on the same beat: a single-lane word with m_fill=1 and m_last=1.
- s_eof at idx==7: one full word with m_fill=8 and m_last=1.
- s_sof/s_eof are ignored when the beat is not accepted.

## Timing
- Reset, synchronous and active-high, clears the following at the clock edge where reset is high:
  - m_valid=0, m_data=0, m_last=0, m_fill=0, err_count=0;
  - idx=0, acc=0.
  - s_ready is 0 while reset is high.
- Reset mid-frame discards the partial word and any unaccepted output word. err_count does not increment.
- Latency: m_valid rises on the edge after the completing beat is accepted, i.e. 1 cycle.
- Output hold: while m_valid && !m_ready, m_data, m_last and m_fill are held stable and s_ready=0.
- Back-to-back: when m_ready stays high, the input accepts one beat per cycle indefinitely with no bubbles. A new word may load in the same cycle the previous one is consumed.
- m_valid falls on the edge after m_valid && m_ready, unless a new word loads on that same edge.
- All outputs are registered except s_ready, which is combinational from m_valid, m_ready and reset.

## Test plan
- Full word: 8 beats with r=0x0001..0x0008 and q=0x1001..0x1008, m_ready=1, sof on beat 1, eof on beat 8. One cycle after beat 8, expect m_valid=1, m_fill=8, m_last=1, m_data[15:0]=0x0001, m_data[31:16]=0x1001, m_data[255:240]=0x1008.
- Partial eof: 3 beats with r=0xAAAA and q=0x5555, eof on beat 3. Expect m_fill=3, m_last=1, m_data[95:0] holding the three pairs and m_data[255:96]=0.
- Truncated frame: 5 beats, then a beat with sof and r=0x00FF. Expect no word emitted, err_count=1, and the next word's lane 1 R=0x00FF.
- Backpressure: m_ready=0 after a word completes. Expect s_ready=0, m_data held stable for 10 cycles, and no beats accepted. When m_ready rises, the word transfers and s_ready=1 in the same cycle.
- Streaming: 64 consecutive beats with m_ready=1 and no sof/eof. Expect 8 words, m_fill=8, m_last=0, one word every 8 cycles, and s_ready=1 throughout.
- Reset mid-frame: assert reset after 4 beats. Expect all outputs to be 0. Then 8 new beats produce a word containing only the new samples, with err_count=0.

Source files
------------

// File: rtl/iq_lane_packer.sv
// iq_lane_packer: packs 16-bit I/Q sample pairs into 256-bit eight-lane words with frame alignment
module iq_lane_packer #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [15:0]          s_r,
    input  logic [15:0]          s_q,
    input  logic                 s_sof,
    input  logic                 s_eof,
    output logic [255:0]         m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic [3:0]           m_fill,
    output logic [ERR_CNT_W-1:0] err_count
);
    logic [2:0]   idx;
    logic [2:0]   lane;
    logic [255:0] acc;
    logic [255:0] merged;
    logic         accept;
    logic         done;
    logic         trunc;
    // sof restarts at lane 1 on an empty base, discarding any partial word
    always_comb begin
        s_ready = !reset && (!m_valid || m_ready);
        accept  = s_valid && s_ready;
        trunc   = s_sof && idx != 3'd0;
        lane    = s_sof ? 3'd0 : idx;
        merged  = (s_sof ? 256'd0 : acc) | (256'({s_q, s_r}) << {lane, 5'd0});
        done    = lane == 3'd7 || s_eof;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            m_fill    <= '0;
            err_count <= '0;
            idx       <= '0;
            acc       <= '0;
        end else begin
            if (m_ready)
                m_valid <= 1'b0;
            if (accept) begin
                if (trunc && !(&err_count))
                    err_count <= err_count + ERR_CNT_W'(1);
                if (done) begin
                    m_valid <= 1'b1;
                    m_data  <= merged;
                    m_fill  <= {1'b0, lane} + 4'd1;
                    m_last  <= s_eof;
                    acc     <= '0;
                    idx     <= '0;
                end else begin
                    acc <= merged;
                    idx <= lane + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iq_lane_packer.sv
// tb_iq_lane_packer: randomized and directed stimulus checked against a queue-based frame model
module tb_iq_lane_packer;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [15:0]  s_r = '0;
    logic [15:0]  s_q = '0;
    logic         s_sof = 1'b0;
    logic         s_eof = 1'b0;
    logic [255:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         m_last;
    logic [3:0]   m_fill;
    logic [15:0]  err_count;

    int vectors = 0;
    int miscompares = 0;
    int words = 0;

    logic [31:0]  lanes[$];
    logic         exp_mv = 1'b0;
    logic [255:0] exp_data = '0;
    logic         exp_last = 1'b0;
    logic [3:0]   exp_fill = '0;
    logic [15:0]  exp_err = '0;

    iq_lane_packer #(.ERR_CNT_W(16)) dut (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_r(s_r), .s_q(s_q), .s_sof(s_sof), .s_eof(s_eof),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .m_fill(m_fill), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one cycle: drive inputs, compare against the model, then advance the model
    task automatic step(input bit v, input logic [15:0] r, input logic [15:0] q,
                        input bit sof, input bit eof, input bit rdy);
        @(negedge clock);
        s_valid = v; s_r = r; s_q = q; s_sof = sof; s_eof = eof; m_ready = rdy;
        #1;
        check("m_valid", 256'(m_valid), 256'(exp_mv));
        if (exp_mv) begin
            check("m_data", m_data, exp_data);
            check("m_last", 256'(m_last), 256'(exp_last));
            check("m_fill", 256'(m_fill), 256'(exp_fill));
        end
        check("s_ready", 256'(s_ready), 256'(!exp_mv || rdy));
        check("err_count", 256'(err_count), 256'(exp_err));
        if (exp_mv && rdy) words++;
        if (v && (!exp_mv || rdy)) begin
            if (rdy) exp_mv = 1'b0;
            if (sof && lanes.size() != 0) begin
                lanes.delete();
                if (exp_err != 16'hFFFF) exp_err++;
            end
            lanes.push_back({q, r});
            if (lanes.size() == 8 || eof) begin
                exp_data = '0;
                foreach (lanes[k]) exp_data[32*k +: 32] = lanes[k];
                exp_fill = 4'(lanes.size());
                exp_last = eof;
                exp_mv = 1'b1;
                lanes.delete();
            end
        end else if (rdy) exp_mv = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        #1;
        check("s_ready_in_reset", 256'(s_ready), 256'(0));
        @(negedge clock);
        check("rst_m_valid", 256'(m_valid), 256'(0));
        check("rst_m_data", m_data, 256'(0));
        check("rst_m_last", 256'(m_last), 256'(0));
        check("rst_m_fill", 256'(m_fill), 256'(0));
        check("rst_err", 256'(err_count), 256'(0));
        reset = 1'b0; s_valid = 1'b0;
        lanes.delete();
        exp_mv = 1'b0;
        exp_err = '0;
    endtask

    initial begin
        int w0;
        do_reset();
        for (int i = 1; i <= 8; i++)
            step(1, 16'(i), 16'h1000 + 16'(i), i == 1, i == 8, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++)
            step(1, 16'hAAAA, 16'h5555, 0, i == 3, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 5; i++)
            step(1, 16'(i), 16'(i), i == 1, 0, 1);
        step(1, 16'h00FF, 16'h0F0F, 1, 0, 1);
        for (int i = 2; i <= 8; i++)
            step(1, 16'(i), 16'(i), 0, i == 8, 1);
        step(1, 16'h7, 16'h7, 1, 1, 0);
        for (int i = 0; i < 10; i++)
            step(1, 16'hDEAD, 16'hBEEF, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        w0 = words;
        for (int i = 0; i < 64; i++)
            step(1, 16'($urandom), 16'($urandom), 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("stream_words", 256'(words - w0), 256'(8));
        for (int i = 0; i < 4; i++)
            step(1, 16'h4444, 16'h4444, i == 0, 0, 1);
        do_reset();
        for (int i = 1; i <= 8; i++)
            step(1, 16'h2000 + 16'(i), 16'h3000 + 16'(i), 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 7);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
